// File: rtl/segre_mmu_arbiter_if.sv
// Shared type and bus bundles for the segre main-memory arbiter.
//   segre_mmu_pkg       : store-size enumeration shared by cache, arbiter and memory.
//   segre_mmu_cache_if  : cache side. Read-miss requests, fill responses and the store push port.
//                         master = cache subsystem, slave = arbiter.
//   segre_mmu_mem_if    : main-memory side. One read channel and one write channel.
//                         master = arbiter, slave = main memory.

package segre_mmu_pkg;
  typedef enum logic [1:0] {
    MEMOP_BYTE = 2'd0,
    MEMOP_HALF = 2'd1,
    MEMOP_WORD = 2'd2
  } memop_data_type_e;
endpackage

interface segre_mmu_cache_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128,
  parameter int WORD_W    = 32
);
  logic [NUM_PORTS-1:0]        req_i;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS-1:0]        rsp_valid_o;
  logic [LINE_W-1:0]           rsp_data_o;
  logic [ADDR_W-1:0]           rsp_addr_o;
  logic                        st_valid_i;
  logic [ADDR_W-1:0]           st_addr_i;
  logic [WORD_W-1:0]           st_data_i;
  segre_mmu_pkg::memop_data_type_e st_type_i;
  logic                        st_ready_o;

  modport master (
    output req_i, req_addr_i, st_valid_i, st_addr_i, st_data_i, st_type_i,
    input  rsp_valid_o, rsp_data_o, rsp_addr_o, st_ready_o
  );

  modport slave (
    input  req_i, req_addr_i, st_valid_i, st_addr_i, st_data_i, st_type_i,
    output rsp_valid_o, rsp_data_o, rsp_addr_o, st_ready_o
  );
endinterface

interface segre_mmu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
);
  logic              mm_rd_req_o;
  logic [ADDR_W-1:0] mm_rd_addr_o;
  logic              mm_data_rdy_i;
  logic [LINE_W-1:0] mm_data_i;
  logic              mm_wr_req_o;
  logic [ADDR_W-1:0] mm_wr_addr_o;
  logic [WORD_W-1:0] mm_wr_data_o;
  segre_mmu_pkg::memop_data_type_e mm_wr_type_o;
  logic              mm_wr_ack_i;

  modport master (
    output mm_rd_req_o, mm_rd_addr_o, mm_wr_req_o, mm_wr_addr_o, mm_wr_data_o, mm_wr_type_o,
    input  mm_data_rdy_i, mm_data_i, mm_wr_ack_i
  );

  modport slave (
    input  mm_rd_req_o, mm_rd_addr_o, mm_wr_req_o, mm_wr_addr_o, mm_wr_data_o, mm_wr_type_o,
    output mm_data_rdy_i, mm_data_i, mm_wr_ack_i
  );
endinterface

// File: rtl/segre_mmu_arbiter.sv
// Main-memory arbiter between the cache subsystem and main memory.
// Latches line-fill misses from NUM_PORTS requesters and serves them round-robin
// with a single outstanding read. Write-through stores sit in a WB_DEPTH-entry
// FIFO and drain between reads; a read whose line matches a buffered store
// forces a drain first.
// Ports:
//   clk_i  : clock
//   rsn_i  : asynchronous active-low reset
//   cache  : segre_mmu_cache_if.slave (miss requests, fill responses, store push)
//   mem    : segre_mmu_mem_if.master  (read/write channels to main memory)
//
// state   | meaning
// IDLE    | choose next action: forced/hazard drain, read grant, opportunistic drain
// RD_REQ  | mm_rd_req_o pulse for the granted port
// RD_WAIT | wait for mm_data_rdy_i, then return the fill
// WR_REQ  | mm_wr_req_o pulse for the write-buffer head
// WR_WAIT | wait for mm_wr_ack_i, then pop the head

module segre_mmu_arbiter
  import segre_mmu_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int LINE_OFF_W = 4,
  parameter int WORD_W     = 32,
  parameter int WB_DEPTH   = 4
) (
  input logic              clk_i,
  input logic              rsn_i,
  segre_mmu_cache_if.slave cache,
  segre_mmu_mem_if.master  mem
);

  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WB_PW     = $clog2(WB_DEPTH);
  localparam int CNT_W     = WB_PW + 1;
  localparam int LINE_HI_W = ADDR_W - LINE_OFF_W;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  state_e state_q, state_d;

  logic [NUM_PORTS-1:0] pending_q;
  logic [ADDR_W-1:0]    addr_q [NUM_PORTS];
  logic [PW-1:0]        rr_q, grant_q, cand_idx;
  logic                 cand_valid, hazard, grant;
  logic [ADDR_W-1:0]    cand_addr, rd_addr_q;

  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [LINE_W-1:0]    rsp_data_q;
  logic [ADDR_W-1:0]    rsp_addr_q;

  logic [ADDR_W-1:0]    wb_addr_q [WB_DEPTH];
  logic [WORD_W-1:0]    wb_data_q [WB_DEPTH];
  memop_data_type_e     wb_type_q [WB_DEPTH];
  logic [WB_PW-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  logic                 wb_full, push, pop, rd_done;

  assign wb_full = (count_q == CNT_W'(WB_DEPTH));
  assign push    = cache.st_valid_i && !wb_full;
  assign pop     = (state_q == WR_WAIT) && mem.mm_wr_ack_i;
  assign rd_done = (state_q == RD_WAIT) && mem.mm_data_rdy_i;

  // Search rr+1 .. rr+NUM_PORTS; iterating backwards lets the earliest match win.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (pending_q[(int'(rr_q) + i) % NUM_PORTS]) begin
        cand_valid = 1'b1;
        cand_idx   = PW'((int'(rr_q) + i) % NUM_PORTS);
      end
    end
  end

  assign cand_addr = addr_q[cand_idx];

  // Only entries between head and head+count are live; the pushing store of this cycle is not seen.
  always_comb begin
    logic [WB_PW-1:0] off;
    hazard = 1'b0;
    off    = '0;
    for (int e = 0; e < WB_DEPTH; e++) begin
      off = WB_PW'(e) - head_q;
      if (({1'b0, off} < count_q) &&
          (wb_addr_q[e][ADDR_W-1:LINE_OFF_W] == cand_addr[ADDR_W-1:LINE_OFF_W]))
        hazard = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_full)                   state_d = WR_REQ;
        else if (cand_valid && hazard) state_d = WR_REQ;
        else if (cand_valid) begin
          state_d = RD_REQ;
          grant   = 1'b1;
        end
        else if (count_q != '0)        state_d = WR_REQ;
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: if (mem.mm_data_rdy_i) state_d = IDLE;
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: if (mem.mm_wr_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      rr_q        <= PW'(NUM_PORTS - 1);
      grant_q     <= '0;
      rd_addr_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      if (grant) begin
        rr_q      <= cand_idx;
        grant_q   <= cand_idx;
        rd_addr_q <= cand_addr;
      end
      if (rd_done) begin
        rsp_valid_q[grant_q] <= 1'b1;
        rsp_data_q           <= mem.mm_data_i;
        rsp_addr_q           <= rd_addr_q;
      end
    end
  end

  // A completing port still has pending set on that edge, so a same-edge request is ignored.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      pending_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) addr_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (cache.req_i[p] && !pending_q[p]) begin
          pending_q[p] <= 1'b1;
          addr_q[p]    <= {cache.req_addr_i[p*ADDR_W+LINE_OFF_W +: LINE_HI_W], {LINE_OFF_W{1'b0}}};
        end else if (rd_done && (grant_q == PW'(p))) begin
          pending_q[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < WB_DEPTH; e++) begin
        wb_addr_q[e] <= '0;
        wb_data_q[e] <= '0;
        wb_type_q[e] <= MEMOP_BYTE;
      end
    end else begin
      if (push) begin
        wb_addr_q[tail_q] <= cache.st_addr_i;
        wb_data_q[tail_q] <= cache.st_data_i;
        wb_type_q[tail_q] <= cache.st_type_i;
        tail_q            <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign cache.rsp_valid_o = rsp_valid_q;
  assign cache.rsp_data_o  = rsp_data_q;
  assign cache.rsp_addr_o  = rsp_addr_q;
  assign cache.st_ready_o  = !wb_full;

  assign mem.mm_rd_req_o   = (state_q == RD_REQ);
  assign mem.mm_rd_addr_o  = rd_addr_q;
  assign mem.mm_wr_req_o   = (state_q == WR_REQ);
  assign mem.mm_wr_addr_o  = wb_addr_q[head_q];
  assign mem.mm_wr_data_o  = wb_data_q[head_q];
  assign mem.mm_wr_type_o  = wb_type_q[head_q];

endmodule
